// File: rtl/sdram_stream_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_bus (interface)
//  Description : Toggle-handshake word-write port between a stream loader
//                and an SDRAM controller. A request is outstanding while
//                req != ack; the controller completes it by making ack == req.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdram_bus #(
    parameter int ADDR_BITS = 22
);
    logic                 req;
    logic                 ack;
    logic                 we;
    logic [ADDR_BITS-1:0] address;
    logic [15:0]          data_write;

    modport master (
        output req,
        output address,
        output we,
        output data_write,
        input  ack
    );

    modport slave (
        input  req,
        input  address,
        input  we,
        input  data_write,
        output ack
    );
endinterface
`default_nettype wire

// File: rtl/sdram_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_stream_loader
//  Description : Packs an 8-bit byte stream into little-endian 16-bit words
//                and writes them to consecutive SDRAM word addresses through
//                a toggle req/ack bus, one request in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_stream_loader #(
    parameter int ADDR_BITS = 22
) (
    input  logic                 sdram_clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   length,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 busy,
    output logic                 done,
    sdram_bus.master             bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LO       = 3'd1,
        ST_HI       = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_FINISH   = 3'd5
    } state_t;

    localparam logic [ADDR_BITS-1:0] PTR_ONE = 1;
    localparam logic [ADDR_BITS:0]   REM_ONE = 1;
    localparam logic [ADDR_BITS:0]   REM_ZERO = '0;

    state_t               state_q;
    logic [ADDR_BITS-1:0] ptr_q;        // next SDRAM word address to write
    logic [ADDR_BITS:0]   remaining_q;  // bytes of the job not yet accepted
    logic                 busy_q;
    logic                 done_q;
    logic                 req_q;
    logic                 we_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [15:0]          wdata_q;

    // Stream is accepted only while collecting the low or high byte of a word
    always_comb begin
        s_ready = (state_q == ST_LO) || (state_q == ST_HI);
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign bus.req        = req_q;
    assign bus.we         = we_q;
    assign bus.address    = addr_q;
    assign bus.data_write = wdata_q;

    // Job sequencer: gathers byte pairs, issues one write, waits for its ack
    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ptr_q       <= base_addr;
                        remaining_q <= length;
                        busy_q      <= 1'b1;
                        state_q     <= (length == REM_ZERO) ? ST_FINISH : ST_LO;
                    end
                end

                ST_LO: begin
                    if (s_valid) begin
                        wdata_q[7:0] <= s_data;
                        remaining_q  <= remaining_q - REM_ONE;
                        if (remaining_q == REM_ONE) begin
                            // Odd-length tail: the word is padded with zero
                            wdata_q[15:8] <= 8'h00;
                            state_q       <= ST_ISSUE;
                        end else begin
                            state_q <= ST_HI;
                        end
                    end
                end

                ST_HI: begin
                    if (s_valid) begin
                        wdata_q[15:8] <= s_data;
                        remaining_q   <= remaining_q - REM_ONE;
                        state_q       <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // A stale ack left over from an aborted job is absorbed here
                    if (req_q == bus.ack) begin
                        addr_q  <= ptr_q;
                        we_q    <= 1'b1;
                        req_q   <= ~req_q;
                        state_q <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    if (bus.ack == req_q) begin
                        ptr_q   <= ptr_q + PTR_ONE;
                        state_q <= (remaining_q == REM_ZERO) ? ST_FINISH : ST_LO;
                    end
                end

                ST_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
